// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register addresses, exception codes and the
// bit positions of the Status/Cause fields.
package cp0_defs;

    localparam logic [7:0] ADDR_BADVADDR = 8'h40;
    localparam logic [7:0] ADDR_COUNT    = 8'h48;
    localparam logic [7:0] ADDR_COMPARE  = 8'h58;
    localparam logic [7:0] ADDR_STATUS   = 8'h60;
    localparam logic [7:0] ADDR_CAUSE    = 8'h68;
    localparam logic [7:0] ADDR_EPC      = 8'h70;

    typedef enum logic [4:0] {
        EXC_INT  = 5'h00,
        EXC_ADEL = 5'h04,
        EXC_ADES = 5'h05,
        EXC_SYS  = 5'h08,
        EXC_BP   = 5'h09,
        EXC_RI   = 5'h0a,
        EXC_OV   = 5'h0c
    } exccode_e;

    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IM_LO = 8;
    localparam int STATUS_IM_HI = 15;
    localparam int STATUS_BEV   = 22;

    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_SW_LO  = 8;
    localparam int CAUSE_SW_HI  = 9;
    localparam int CAUSE_HW_LO  = 10;
    localparam int CAUSE_HW_HI  = 15;
    localparam int CAUSE_TI     = 30;
    localparam int CAUSE_BD     = 31;

    // Only address-error exceptions carry a meaningful faulting address.
    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_regfile_timer.sv
// CP0 Count/Compare timer: divided Count tick, Compare match and the TI flag.
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic        phase;
    logic        tick;
    logic [31:0] count_inc;

    assign tick      = (COUNT_DIV == 1) ? 1'b1 : phase;
    assign count_inc = count + 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase   <= 1'b0;
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            phase <= (COUNT_DIV == 1) ? 1'b0 : ~phase;

            if (count_we)
                count <= wdata;
            else if (tick)
                count <= count_inc;

            if (compare_we)
                compare <= wdata;

            // A Compare write clears TI even if a match lands on the same edge.
            if (compare_we)
                ti <= 1'b0;
            else if (tick && !count_we && (count_inc == compare))
                ti <= 1'b1;
        end
    end

endmodule

// File: rtl/cp0_regfile.sv
// MIPS CP0 register file: Status/Cause/EPC/BadVAddr plus the Count/Compare
// timer, committed from WB, with a combinational mfc0 port and int_pending.
module cp0_regfile
    import cp0_defs::*;
#(
    parameter int N_EXT_INT = 6,
    parameter int COUNT_DIV = 2,
    parameter int TIMER_IP  = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mtc0_we,
    input  logic [7:0]           cp0_addr,
    input  logic [31:0]          cp0_wdata,
    output logic [31:0]          cp0_rdata,
    input  logic                 eret_flush,
    input  logic                 wb_ex,
    input  logic [4:0]           wb_exccode,
    input  logic                 wb_bd,
    input  logic [31:0]          wb_pc,
    input  logic [31:0]          wb_badvaddr,
    input  logic [N_EXT_INT-1:0] ext_int_in,
    output logic [31:0]          cp0_status,
    output logic [31:0]          cp0_cause,
    output logic [31:0]          cp0_epc,
    output logic                 int_pending
);

    logic [7:0]  status_im;
    logic        status_exl;
    logic        status_ie;
    logic        cause_bd;
    logic [4:0]  cause_exc;
    logic [1:0]  cause_ip_sw;
    logic [5:0]  cause_ip_hw;
    logic [5:0]  ip_hw_next;
    logic [31:0] epc;
    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;
    logic        mtc0_ok;

    // Exceptions and eret pre-empt any mtc0 committed on the same edge.
    assign mtc0_ok = mtc0_we && !wb_ex && !eret_flush;

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (mtc0_ok && (cp0_addr == ADDR_COUNT)),
        .compare_we (mtc0_ok && (cp0_addr == ADDR_COMPARE)),
        .wdata      (cp0_wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    always_comb begin
        ip_hw_next = '0;
        ip_hw_next[N_EXT_INT-1:0] = ext_int_in;
        ip_hw_next[TIMER_IP-2] = ip_hw_next[TIMER_IP-2] | ti;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_im   <= '0;
            status_exl  <= 1'b0;
            status_ie   <= 1'b0;
            cause_bd    <= 1'b0;
            cause_exc   <= '0;
            cause_ip_sw <= '0;
            cause_ip_hw <= '0;
            epc         <= '0;
            badvaddr    <= '0;
        end else begin
            cause_ip_hw <= ip_hw_next;

            if (wb_ex) begin
                cause_exc  <= wb_exccode;
                status_exl <= 1'b1;
                // Nested exceptions keep the original return point.
                if (!status_exl) begin
                    cause_bd <= wb_bd;
                    epc      <= wb_bd ? (wb_pc - 32'd4) : wb_pc;
                end
                if (is_addr_exc(wb_exccode))
                    badvaddr <= wb_badvaddr;
            end else if (eret_flush) begin
                status_exl <= 1'b0;
            end else if (mtc0_ok) begin
                case (cp0_addr)
                    ADDR_STATUS: begin
                        status_im  <= cp0_wdata[STATUS_IM_HI:STATUS_IM_LO];
                        status_exl <= cp0_wdata[STATUS_EXL];
                        status_ie  <= cp0_wdata[STATUS_IE];
                    end
                    ADDR_CAUSE: cause_ip_sw <= cp0_wdata[CAUSE_SW_HI:CAUSE_SW_LO];
                    ADDR_EPC:   epc         <= cp0_wdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        cp0_status = '0;
        cp0_status[STATUS_BEV] = 1'b1;
        cp0_status[STATUS_IM_HI:STATUS_IM_LO] = status_im;
        cp0_status[STATUS_EXL] = status_exl;
        cp0_status[STATUS_IE]  = status_ie;

        cp0_cause = '0;
        cp0_cause[CAUSE_BD] = cause_bd;
        cp0_cause[CAUSE_TI] = ti;
        cp0_cause[CAUSE_HW_HI:CAUSE_HW_LO]   = cause_ip_hw;
        cp0_cause[CAUSE_SW_HI:CAUSE_SW_LO]   = cause_ip_sw;
        cp0_cause[CAUSE_EXC_HI:CAUSE_EXC_LO] = cause_exc;
    end

    assign cp0_epc = epc;

    assign int_pending = status_ie && !status_exl &&
                         |(cp0_cause[CAUSE_HW_HI:CAUSE_SW_LO] & status_im);

    always_comb begin
        case (cp0_addr)
            ADDR_BADVADDR: cp0_rdata = badvaddr;
            ADDR_COUNT:    cp0_rdata = count;
            ADDR_COMPARE:  cp0_rdata = compare;
            ADDR_STATUS:   cp0_rdata = cp0_status;
            ADDR_CAUSE:    cp0_rdata = cp0_cause;
            ADDR_EPC:      cp0_rdata = epc;
            default:       cp0_rdata = '0;
        endcase
    end

endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
Parametrised MIPS CP0 register file, successor to the status/cause/epc-only block. Adds the Count/Compare timer with a configurable tick divider, BadVAddr, a combinational mfc0 read port, a configurable external interrupt width, and an interrupt-pending output to the decode stage. Sits beside WB: WB commits exceptions, mtc0 and eret here; decode samples int_pending to tag the next instruction with an Int exception.

Parameters:
N_EXT_INT, 6, number of hardware interrupt lines (1..6); they map to IP2 upward, and unused IP bits read 0.
COUNT_DIV, 2, core cycles per Count increment (1 or 2).
TIMER_IP, 7, Cause.IP bit ORed with Cause.TI (2..7).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
mtc0_we  in  1  mtc0 commit from WB
cp0_addr  in  8  {rd[4:0], sel[2:0]}
cp0_wdata  in  32  mtc0 data
cp0_rdata  out  32  mfc0 data, combinational on cp0_addr
eret_flush  in  1  eret commit from WB
wb_ex  in  1  exception commit from WB
wb_exccode  in  5  exception code
wb_bd  in  1  faulting instruction is in a delay slot
wb_pc  in  32  faulting PC
wb_badvaddr  in  32  faulting address (AdEL/AdES)
ext_int_in  in  N_EXT_INT  hardware interrupt lines, level-sensitive
cp0_status  out  32  Status register
cp0_cause  out  32  Cause register
cp0_epc  out  32  EPC register
int_pending  out  1  interrupt request to decode

Behaviour:
- Register map (cp0_addr):
  - 0x40 BadVAddr (read-only)
  - 0x48 Count
  - 0x58 Compare
  - 0x60 Status
  - 0x68 Cause
  - 0x70 EPC
  - Any other address reads 0; writes to it are ignored.
- Reset values:
  - Status = 0x0040_0000 (BEV=1, IM=0, EXL=0, IE=0).
  - Cause, EPC, BadVAddr, Count, Compare = 0.
  - int_pending = 0.
  - Divider phase = 0.
- Status write: only IM[15:8], EXL[1] and IE[0] are writable; BEV is fixed at 1.
- Cause write: only IP[9:8] is writable.
- Cause.IP[2+N_EXT_INT-1:2]:
  - Registered copy of ext_int_in, so a line change appears 1 cycle later.
  - Bit TIMER_IP is additionally ORed with TI.
- Count tick:
  - Count increments by 1, wrapping 0xFFFF_FFFF -> 0.
  - COUNT_DIV=2: on every cycle where the divider phase is 1; the phase toggles every cycle.
  - COUNT_DIV=1: every cycle.
- Count write: mtc0 to Count loads wdata and takes priority over a tick in the same cycle. The divider phase is unaffected.
- TI set: on a tick where the incremented Count value equals Compare. A Count write never sets TI.
- TI clear: mtc0 to Compare clears TI. Clear wins over a same-cycle set.
- Exception commit (wb_ex=1):
  - Cause.ExcCode <= wb_exccode and Status.EXL <= 1.
  - If EXL was 0: Cause.BD <= wb_bd and EPC <= wb_bd ? wb_pc-4 : wb_pc.
  - If EXL was already 1: BD and EPC are unchanged.
- BadVAddr: loaded from wb_badvaddr when wb_ex=1 and exccode is 0x04 (AdEL) or 0x05 (AdES). No other path writes it.
- Priority, highest first:
  1. rst
  2. wb_ex
  3. eret_flush
  4. mtc0_we
  - A lower-priority event in the same cycle is ignored for every register, Count/Compare included.
  - The timer tick and the ext_int sampling are independent of this order.
- eret_flush: clears Status.EXL.
- int_pending: combinational = IE & ~EXL & |(Cause.IP & Status.IM).
- Reads: cp0_rdata reflects the registered value, with no write bypass. An mfc0 in the same cycle as an mtc0 to the same address returns the old value.
- All writes take effect at the next clk edge. Reset mid-operation returns every field to its reset value on that edge.

Decomposition:
- Shared package cp0_defs holds:
  - The register-address constants (BADVADDR/COUNT/COMPARE/STATUS/CAUSE/EPC).
  - The exccode constants (INT=0x00, ADEL=0x04, ADES=0x05, SYS=0x08, BP=0x09, RI=0x0a, OV=0x0c).
  - The Status/Cause bit-position constants.
- One sub-module, cp0_timer:
  - Contains the divider phase, Count, Compare and TI.
  - Inputs: count/compare write enables, wdata.
  - Outputs: count, compare, ti.

Test Plan:
- Reset -> Status=0x0040_0000; Cause, EPC, Count = 0; int_pending=0. mfc0 to 0x78 -> 0.
- Exception with pc=0xBFC0_0100, bd=1, exccode=0x0c, EXL=0 -> EPC=0xBFC0_00FC, Cause=0x8000_0030, Status.EXL=1. A second wb_ex with exccode=0x08 -> EPC unchanged, ExcCode=0x08.
- AdEL (0x04) with badvaddr=0x8000_0003 -> BadVAddr=0x8000_0003. A following Ov exception leaves BadVAddr unchanged.
- COUNT_DIV=2: write Count=0x10, Compare=0x14 -> TI=1 about 8 cycles later, Cause.IP7=1 one cycle after that. With Status=0x0000_8001, int_pending=1. mtc0 to Compare -> TI=0, then int_pending=0.
- Count=0xFFFF_FFFF at a tick -> Count=0. Same-cycle tick and Count write of 0x55 -> Count=0x55.
- Same-cycle wb_ex and mtc0 Status=0x0000_0001 -> Status.IE unchanged and EXL=1. ext_int_in[0]=1 with IM2=1, IE=1 -> int_pending asserts 1 cycle later. eret_flush -> EXL=0.
